// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler sharing one floating-point adder between NREQ requesters.
// One operation in flight; result sampled ADD_LAT cycles after the operands are driven.
module fp_add_scheduler #(
  parameter  int NREQ    = 4,
  parameter  int ADD_LAT = 2,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ-1:0]    req_op,
  output logic [31:0]        add_a,
  output logic [31:0]        add_b,
  output logic               add_op,
  input  logic [31:0]        add_sum,
  input  logic               add_zero,
  input  logic               add_ovf,
  input  logic               add_unf,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_sum,
  output logic [2:0]         rsp_flags,
  output logic               busy
);

  localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    add_a_q, add_a_d;
  logic [31:0]    add_b_q, add_b_d;
  logic           add_op_q, add_op_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]    rsp_sum_q, rsp_sum_d;
  logic [2:0]     rsp_flags_q, rsp_flags_d;

  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] cand;

  // Search starts at rr_ptr and wraps, so the first valid found is the fair winner.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  assign req_ready = (!rst && state_q == IDLE && grant_found) ? (NREQ'(1) << grant_id) : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gid_d       = gid_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_op_d    = add_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_flags_d = rsp_flags_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          add_a_d  = req_a[32*grant_id +: 32];
          add_b_d  = req_b[32*grant_id +: 32];
          add_op_d = req_op[grant_id];
          gid_d    = grant_id;
          cnt_d    = CW'(ADD_LAT - 1);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rsp_sum_d   = add_sum;
          rsp_flags_d = {add_ovf, add_unf, add_zero};
          rsp_id_d    = gid_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        // Pointer moves past the served requester only once its response is taken.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (gid_q == IDW'(NREQ - 1)) ? '0 : gid_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gid_q       <= '0;
      cnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_op_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gid_q       <= gid_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_op_q    <= add_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_op    = add_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_flags = rsp_flags_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Directed bench for fp_add_scheduler with a table-driven adder model whose
// result only becomes correct ADD_LAT cycles after its operands change.
`timescale 1ns/1ps
module tb_fp_add_scheduler;
  localparam int NREQ    = 4;
  localparam int ADD_LAT = 2;
  localparam int IDW     = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    req_op;
  logic [31:0]        add_a, add_b;
  logic               add_op;
  logic [31:0]        add_sum;
  logic               add_zero, add_ovf, add_unf;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_sum;
  logic [2:0]         rsp_flags;
  logic               busy;

  int checks   = 0;
  int failures = 0;

  fp_add_scheduler #(.NREQ(NREQ), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .add_a(add_a), .add_b(add_b), .add_op(add_op),
    .add_sum(add_sum), .add_zero(add_zero), .add_ovf(add_ovf), .add_unf(add_unf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_flags(rsp_flags),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Hand-computed IEEE-754 results, returned as {ovf, unf, zero, sum}.
  function automatic logic [34:0] fp_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic op);
    case ({op, a, b})
      {1'b0, 32'h3F800000, 32'h40000000}: return {3'b000, 32'h40400000};
      {1'b1, 32'h40400000, 32'h3F800000}: return {3'b000, 32'h40000000};
      {1'b1, 32'h3F800000, 32'h3F800000}: return {3'b001, 32'h00000000};
      {1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF}: return {3'b100, 32'h7F800000};
      {1'b0, 32'h3F800000, 32'h3F800000}: return {3'b000, 32'h40000000};
      {1'b0, 32'h40000000, 32'h40000000}: return {3'b000, 32'h40800000};
      {1'b0, 32'h40800000, 32'h3F800000}: return {3'b000, 32'h40A00000};
      {1'b0, 32'h40400000, 32'h40400000}: return {3'b000, 32'h40C00000};
      {1'b1, 32'h40000000, 32'h3F800000}: return {3'b000, 32'h3F800000};
      default:                            return {3'b000, 32'h7FC0DEAD};
    endcase
  endfunction

  // Model settles ADD_LAT-1 edges after the operands are registered by the DUT.
  logic [34:0] pipe [ADD_LAT-1];
  initial foreach (pipe[s]) pipe[s] = {3'b000, 32'h7FC0BEEF};
  always @(posedge clk) begin
    pipe[0] <= fp_model(add_a, add_b, add_op);
    for (int s = 1; s < ADD_LAT - 1; s++) pipe[s] <= pipe[s-1];
  end
  assign {add_ovf, add_unf, add_zero, add_sum} = pipe[ADD_LAT-2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raises req_valid[i], waits for the grant, drops it after the transfer and
  // returns the grant wait and the cycle count from T+1 until rsp_valid.
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic op, output int gwait, output int lat);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[i]         = op;
    req_valid[i]      = 1'b1;
    #1;
    gwait = 0;
    while (!req_ready[i] && gwait < 40) begin
      step();
      gwait++;
    end
    step();
    req_valid[i] = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    step();
    step();
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if ({add_a, add_b, add_op} !== 65'd0) begin failures++; $display("FAIL reset_add got=%h/%h/%b exp=0", add_a, add_b, add_op); end
    checks++; if ({rsp_id, rsp_sum, rsp_flags} !== 37'd0) begin failures++; $display("FAIL reset_rsp got=%0d/%h/%b exp=0", rsp_id, rsp_sum, rsp_flags); end
    req_valid = '0;
    rst       = 1'b0;
    step();
  endtask

  task automatic test_add();
    int gw, lat;
    rsp_ready = 1'b1;
    issue(0, 32'h3F800000, 32'h40000000, 1'b0, gw, lat);
    checks++; if (gw !== 0) begin failures++; $display("FAIL add_grant_wait got=%0d exp=0", gw); end
    checks++; if (lat !== ADD_LAT + 1) begin failures++; $display("FAIL add_latency got=%0d exp=%0d", lat, ADD_LAT + 1); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL add_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_sum !== 32'h40400000) begin failures++; $display("FAIL add_sum got=%h exp=40400000", rsp_sum); end
    checks++; if (rsp_flags !== 3'b000) begin failures++; $display("FAIL add_flags got=%b exp=000", rsp_flags); end
    step();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL add_done got=%b/%b exp=0/0", rsp_valid, busy); end
  endtask

  task automatic test_sub();
    int gw, lat;
    rsp_ready = 1'b1;
    issue(2, 32'h40400000, 32'h3F800000, 1'b1, gw, lat);
    checks++; if (lat !== ADD_LAT + 1 || rsp_id !== 2'd2) begin failures++; $display("FAIL sub1_lat_id got=%0d/%0d exp=%0d/2", lat, rsp_id, ADD_LAT + 1); end
    checks++; if (rsp_sum !== 32'h40000000 || rsp_flags !== 3'b000) begin failures++; $display("FAIL sub1_result got=%h/%b exp=40000000/000", rsp_sum, rsp_flags); end
    step();
    issue(2, 32'h3F800000, 32'h3F800000, 1'b1, gw, lat);
    checks++; if (rsp_sum !== 32'h00000000 || rsp_flags !== 3'b001) begin failures++; $display("FAIL sub_zero got=%h/%b exp=00000000/001", rsp_sum, rsp_flags); end
    step();
    issue(1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, gw, lat);
    checks++; if (rsp_id !== 2'd1 || rsp_sum !== 32'h7F800000 || rsp_flags !== 3'b100) begin failures++; $display("FAIL add_ovf got=%0d/%h/%b exp=1/7F800000/100", rsp_id, rsp_sum, rsp_flags); end
    step();
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_sum [4];
    int gnt_id [5];
    int gnt_cyc [5];
    int r_id [5];
    logic [31:0] r_sum [5];
    int ngrant, nresp, cyc;
    exp_sum = '{32'h40000000, 32'h40800000, 32'h40400000, 32'h40A00000};
    foreach (gnt_id[k]) begin
      gnt_id[k] = -1; gnt_cyc[k] = -100; r_id[k] = -1; r_sum[k] = '0;
    end
    rst = 1'b1;
    #2;
    rst = 1'b0;
    req_a     = {32'h40800000, 32'h3F800000, 32'h40000000, 32'h3F800000};
    req_b     = {32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F800000};
    req_op    = '0;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    ngrant = 0;
    nresp  = 0;
    cyc    = 0;
    while (nresp < 5 && cyc < 80) begin
      checks++; if ($countones(req_ready) > 1) begin failures++; $display("FAIL rr_onehot cyc=%0d got=%b exp=at most one", cyc, req_ready); end
      if (req_ready != '0 && ngrant < 5) begin
        for (int j = 0; j < NREQ; j++) if (req_ready[j]) gnt_id[ngrant] = j;
        gnt_cyc[ngrant] = cyc;
        ngrant++;
      end
      if (rsp_valid && rsp_ready) begin
        r_id[nresp]  = int'(rsp_id);
        r_sum[nresp] = rsp_sum;
        nresp++;
        if (nresp == 5) req_valid = '0;
      end
      step();
      cyc++;
    end
    checks++; if (nresp !== 5) begin failures++; $display("FAIL rr_timeout got=%0d responses exp=5", nresp); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (gnt_id[k] !== k % 4) begin failures++; $display("FAIL rr_grant_order k=%0d got=%0d exp=%0d", k, gnt_id[k], k % 4); end
      checks++; if (r_id[k] !== k % 4 || r_sum[k] !== exp_sum[k % 4]) begin failures++; $display("FAIL rr_response k=%0d got=%0d/%h exp=%0d/%h", k, r_id[k], r_sum[k], k % 4, exp_sum[k % 4]); end
      if (k > 0) begin
        checks++; if (gnt_cyc[k] - gnt_cyc[k-1] !== ADD_LAT + 2) begin failures++; $display("FAIL rr_interval k=%0d got=%0d exp=%0d", k, gnt_cyc[k] - gnt_cyc[k-1], ADD_LAT + 2); end
      end
    end
  endtask

  task automatic test_backpressure();
    int gw, lat;
    rsp_ready = 1'b0;
    issue(0, 32'h40400000, 32'h40400000, 1'b0, gw, lat);
    checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'h40C00000) begin failures++; $display("FAIL bp_first got=%b/%h exp=1/40C00000", rsp_valid, rsp_sum); end
    req_a[32 +: 32] = 32'h40000000;
    req_b[32 +: 32] = 32'h3F800000;
    req_op[1]       = 1'b1;
    req_valid[1]    = 1'b1;
    #1;
    for (int c = 0; c < 10; c++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'h40C00000 || rsp_id !== 2'd0) begin failures++; $display("FAIL bp_hold c=%0d got=%b/%h/%0d exp=1/40C00000/0", c, rsp_valid, rsp_sum, rsp_id); end
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_req_ready c=%0d got=%b exp=0000", c, req_ready); end
      step();
    end
    rsp_ready = 1'b1;
    step();
    checks++; if (req_ready !== 4'b0010 || rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_regrant got=%b/%b exp=0010/0", req_ready, rsp_valid); end
    step();
    req_valid[1] = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      step();
      lat++;
    end
    checks++; if (lat !== ADD_LAT + 1 || rsp_id !== 2'd1 || rsp_sum !== 32'h3F800000) begin failures++; $display("FAIL bp_second got=%0d/%0d/%h exp=%0d/1/3F800000", lat, rsp_id, rsp_sum, ADD_LAT + 1); end
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    rsp_ready = 1'b1;
    req_a[64 +: 32] = 32'h40000000;
    req_b[64 +: 32] = 32'h3F800000;
    req_op[2]       = 1'b1;
    req_valid[2]    = 1'b1;
    #1;
    n = 0;
    while (!req_ready[2] && n < 40) begin
      step();
      n++;
    end
    step();
    checks++; if (busy !== 1'b1 || add_a !== 32'h40000000 || add_op !== 1'b1) begin failures++; $display("FAIL rstmid_wait got=%b/%h/%b exp=1/40000000/1", busy, add_a, add_op); end
    rst = 1'b1;
    #1;
    checks++; if ({add_a, add_b, add_op} !== 65'd0) begin failures++; $display("FAIL rstmid_add got=%h/%h/%b exp=0", add_a, add_b, add_op); end
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin failures++; $display("FAIL rstmid_ctrl got=%b/%b/%b exp=0/0/0000", rsp_valid, busy, req_ready); end
    step();
    req_valid = '0;
    rst       = 1'b0;
    for (int c = 0; c < ADD_LAT + 3; c++) begin
      step();
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_no_rsp c=%0d got=%b exp=0", c, rsp_valid); end
    end
    req_a[0 +: 32] = 32'h3F800000;
    req_b[0 +: 32] = 32'h40000000;
    req_op[0]      = 1'b0;
    req_valid      = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rstmid_ptr got=%b exp=0001", req_ready); end
    step();
    req_valid = '0;
    n = 1;
    while (!rsp_valid && n < 40) begin
      step();
      n++;
    end
    checks++; if (rsp_id !== 2'd0 || rsp_sum !== 32'h40400000) begin failures++; $display("FAIL rstmid_resume got=%0d/%h exp=0/40400000", rsp_id, rsp_sum); end
    step();
  endtask

  task automatic test_drop();
    int n;
    rsp_ready = 1'b1;
    req_a[0 +: 32] = 32'h3F800000;
    req_b[0 +: 32] = 32'h3F800000;
    req_op[0]      = 1'b0;
    req_valid[0]   = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL drop_grant0 got=%b exp=0001", req_ready); end
    step();
    req_valid[0] = 1'b0;
    req_valid[3] = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin failures++; $display("FAIL drop_busy got=%b/%b exp=0000/1", req_ready, busy); end
    step();
    req_valid[3] = 1'b0;
    n = 2;
    while (!rsp_valid && n < 40) begin
      step();
      n++;
    end
    checks++; if (rsp_id !== 2'd0 || rsp_sum !== 32'h40000000) begin failures++; $display("FAIL drop_rsp got=%0d/%h exp=0/40000000", rsp_id, rsp_sum); end
    step();
    for (int c = 0; c < ADD_LAT + 4; c++) begin
      checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin failures++; $display("FAIL drop_idle c=%0d got=%b/%b exp=0000/0", c, req_ready, rsp_valid); end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
